execute_unit: RTL

Execute stage that consumes the shifter's output (`Shifted`) as operand B and the first register operand as operand A. It performs one ARM-style data-processing operation or an iterative 32×32 multiply, maintains the NZCV flag register, and presents a registered result to writeback. Transfers use valid/ready handshakes on both sides.

---
 rtl/exec_pkg.sv | 43 ++++
 rtl/mul_iter.sv | 73 +++++++
 rtl/execute_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcode and FSM enums, NZCV bit positions.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package exec_pkg;

    // ARM data-processing opcodes, encoded as in the instruction word.
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_EOR = 4'd1,
        OP_SUB = 4'd2,
        OP_RSB = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SBC = 4'd6,
        OP_RSC = 4'd7,
        OP_TST = 4'd8,
        OP_TEQ = 4'd9,
        OP_CMP = 4'd10,
        OP_CMN = 4'd11,
        OP_ORR = 4'd12,
        OP_MOV = 4'd13,
        OP_BIC = 4'd14,
        OP_MVN = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } exec_state_t;

    // Bit positions inside the 4-bit NZCV register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare/test ops only produce flags; they never write a register.
    function automatic logic is_compare(alu_op_t op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low WIDTH bits kept.
// Latency: start at edge k, done/product valid in the cycle before edge k+MUL_CYCLES.
// Backpressure: none; caller must capture product the cycle done is high.
// Ports: clk/rst_n, start (loads operands), multiplicand/multiplier in,
//        done (combinational, final iteration), product (combinational final sum).
module mul_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MUL_CYCLES - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        // The last iteration's sum is handed out directly so the caller can
        // register it on the same edge that would have stored it here.
        done     = run_q && (cnt_q == LAST_CNT);
        product  = acc_next;
        if (start) begin
            mcand_d  = multiplicand;
            mplier_d = multiplier;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: one ARM data-processing op per cycle or an iterative multiply, NZCV upkeep.
// Latency: ALU ops 1 cycle; multiply MUL_CYCLES cycles (busy meanwhile).
// Backpressure: result held in HOLD until out_ready; in_ready drops while busy or stalled.
// Optional feature macro: EXECUTE_MUL_EN (multiply path, MUL state, busy). Without it
// Mul is ignored and busy is tied low.
// Ports: in_valid/in_ready + SrcA, Shifted, ShiftCarry, ALUOp, Mul, SetFlags in;
//        out_valid/out_ready + ALUResult, RegWrite, Flags (NZCV, bit 3 = N), busy out.
module execute_unit
    import exec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] Shifted,
    input  logic             ShiftCarry,
    input  logic [3:0]       ALUOp,
    input  logic             Mul,
    input  logic             SetFlags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             RegWrite,
    output logic [3:0]       Flags,
    output logic             busy
);

    exec_state_t      state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             regwrite_q, regwrite_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;

    alu_op_t          op;
    logic [WIDTH-1:0] opx, opy, logic_res, alu_res;
    logic [WIDTH:0]   sum;
    logic             cin, arith;
    logic [3:0]       alu_flags;

`ifdef EXECUTE_MUL_EN
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             mul_setf_q, mul_setf_d;
    logic             busy_q, busy_d;

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_iter (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (SrcA),
        .multiplier   (Shifted),
        .done         (mul_done),
        .product      (mul_product)
    );

    assign busy = busy_q;
`else
    logic mul_unused;
    localparam int unused_mul_cycles = MUL_CYCLES;
    assign mul_unused = Mul;
    assign busy       = 1'b0;
`endif

    assign op        = alu_op_t'(ALUOp);
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign RegWrite  = regwrite_q;
    assign Flags     = flags_q;

    // Combinational ALU. Subtracts are done as x + ~y + cin so C comes out
    // in the ARM "no borrow" sense without extra inversion.
    always_comb begin
        opx       = SrcA;
        opy       = Shifted;
        cin       = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (op)
            OP_ADD, OP_CMN: cin = 1'b0;
            OP_ADC:         cin = flags_q[FLAG_C];
            OP_SUB, OP_CMP: begin opy = ~Shifted; cin = 1'b1; end
            OP_SBC:         begin opy = ~Shifted; cin = flags_q[FLAG_C]; end
            OP_RSB:         begin opx = Shifted; opy = ~SrcA; cin = 1'b1; end
            OP_RSC:         begin opx = Shifted; opy = ~SrcA; cin = flags_q[FLAG_C]; end
            default:        arith = 1'b0;
        endcase
        case (op)
            OP_AND, OP_TST: logic_res = SrcA & Shifted;
            OP_EOR, OP_TEQ: logic_res = SrcA ^ Shifted;
            OP_ORR:         logic_res = SrcA | Shifted;
            OP_MOV:         logic_res = Shifted;
            OP_BIC:         logic_res = SrcA & ~Shifted;
            OP_MVN:         logic_res = ~Shifted;
            default:        logic_res = '0;
        endcase
        sum     = {1'b0, opx} + {1'b0, opy} + {{WIDTH{1'b0}}, cin};
        alu_res = arith ? sum[WIDTH-1:0] : logic_res;

        alu_flags         = flags_q;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        if (arith) begin
            alu_flags[FLAG_C] = sum[WIDTH];
            // Overflow: both addends share a sign that the result does not.
            alu_flags[FLAG_V] = (opx[WIDTH-1] == opy[WIDTH-1]) &&
                                (sum[WIDTH-1] != opx[WIDTH-1]);
        end else begin
            alu_flags[FLAG_C] = ShiftCarry;
        end
    end

    // Next-state / next-output logic.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        regwrite_d  = regwrite_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
`ifdef EXECUTE_MUL_EN
        mul_start   = 1'b0;
        mul_setf_d  = mul_setf_q;
`endif

        case (state_q)
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
`ifdef EXECUTE_MUL_EN
            S_MUL: begin
                if (mul_done) begin
                    state_d     = S_HOLD;
                    result_d    = mul_product;
                    regwrite_d  = 1'b1;
                    out_valid_d = 1'b1;
                    if (mul_setf_q) begin
                        flags_d[FLAG_N] = mul_product[WIDTH-1];
                        flags_d[FLAG_Z] = (mul_product == '0);
                    end
                end
            end
`endif
            default: ;
        endcase

        // A new op accepted in HOLD overrides the drain above: no bubble.
        if (accept) begin
`ifdef EXECUTE_MUL_EN
            if (Mul) begin
                mul_start   = 1'b1;
                mul_setf_d  = SetFlags;
                state_d     = S_MUL;
                out_valid_d = 1'b0;
            end else
`endif
            begin
                state_d     = S_HOLD;
                result_d    = alu_res;
                regwrite_d  = !is_compare(op);
                out_valid_d = 1'b1;
                if (SetFlags) begin
                    flags_d = alu_flags;
                end
            end
        end

`ifdef EXECUTE_MUL_EN
        busy_d = (state_d == S_MUL);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            regwrite_q  <= 1'b0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
`ifdef EXECUTE_MUL_EN
            mul_setf_q  <= 1'b0;
            busy_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            regwrite_q  <= regwrite_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef EXECUTE_MUL_EN
            mul_setf_q  <= mul_setf_d;
            busy_q      <= busy_d;
`endif
        end
    end

endmodule
